// File: rtl/mf_ctrl_delay_line.sv
// Fixed-depth delay line for a window-counter value and its start strobe.
// It provides a selectable intermediate tap, a strobe occupancy count and rising-edge detection.
module mf_ctrl_delay_line #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 2,
  parameter int TAP_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              strb_in,
  input  logic [TAP_W-1:0]  tap_sel,
  output logic [DATA_W-1:0] data_out,
  output logic              strb_out,
  output logic [DATA_W-1:0] tap_data,
  output logic              tap_strb,
  output logic              strb_rise,
  output logic [CNT_W-1:0]  inflight,
  output logic              busy,
  output logic              tap_err
);

  localparam logic [TAP_W:0] DEPTH_CMP = (TAP_W+1)'(DEPTH);

  // Index 0 is stage 1, nearest the input; index DEPTH-1 drives the outputs.
  logic [DATA_W-1:0] stg_data [DEPTH];
  logic [DEPTH-1:0]  stg_strb;
  logic [CNT_W-1:0]  cnt;
  logic              prev_out;

  // en advances every stage together; clr flushes and overrides en.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_data[k] <= '0;
        stg_strb[k] <= 1'b0;
      end
      cnt <= '0;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_data[k] <= '0;
        stg_strb[k] <= 1'b0;
      end
      cnt <= '0;
    end else if (en) begin
      stg_data[0] <= data_in;
      stg_strb[0] <= strb_in;
      for (int k = 1; k < DEPTH; k++) begin
        stg_data[k] <= stg_data[k-1];
        stg_strb[k] <= stg_strb[k-1];
      end
      // One strobe enters and one leaves per shift, so the count tracks the popcount.
      case ({strb_in, stg_strb[DEPTH-1]})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Edge history runs on every clock so a rise is still seen while stalled.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) prev_out <= 1'b0;
    else      prev_out <= stg_strb[DEPTH-1];
  end

  assign data_out  = stg_data[DEPTH-1];
  assign strb_out  = stg_strb[DEPTH-1];
  assign strb_rise = stg_strb[DEPTH-1] & ~prev_out;
  assign inflight  = cnt;
  assign busy      = (cnt != '0);
  assign tap_err   = ({1'b0, tap_sel} >= DEPTH_CMP);

  // Out-of-range selects fall back to the last stage.
  always_comb begin
    tap_data = stg_data[DEPTH-1];
    tap_strb = stg_strb[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, tap_sel} == (TAP_W+1)'(i)) begin
        tap_data = stg_data[i];
        tap_strb = stg_strb[i];
      end
    end
  end

endmodule

// File: tb/tb_mf_ctrl_delay_line.sv
// Directed bench for mf_ctrl_delay_line at DATA_W=4, DEPTH=2.
// Each step drives inputs, clocks once and checks outputs 1 ns after the edge.
module tb_mf_ctrl_delay_line;

  logic       CLK = 1'b0;
  logic       RST;
  logic       en;
  logic       clr;
  logic [3:0] data_in;
  logic       strb_in;
  logic [3:0] tap_sel;
  logic [3:0] data_out;
  logic       strb_out;
  logic [3:0] tap_data;
  logic       tap_strb;
  logic       strb_rise;
  logic [4:0] inflight;
  logic       busy;
  logic       tap_err;

  int n_checks = 0;
  int n_errors = 0;

  mf_ctrl_delay_line #(.DATA_W(4), .DEPTH(2), .TAP_W(4), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .en(en), .clr(clr), .data_in(data_in),
    .strb_in(strb_in), .tap_sel(tap_sel), .data_out(data_out),
    .strb_out(strb_out), .tap_data(tap_data), .tap_strb(tap_strb),
    .strb_rise(strb_rise), .inflight(inflight), .busy(busy), .tap_err(tap_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Strobe-side snapshot: tap_strb, strb_out, strb_rise, inflight, busy.
  task automatic check_strb(input string tag, input logic ts, input logic so,
                            input logic sr, input int inf, input logic bz);
    check({tag, "_tap_strb"}, 32'(tap_strb), 32'(ts));
    check({tag, "_strb_out"}, 32'(strb_out), 32'(so));
    check({tag, "_strb_rise"}, 32'(strb_rise), 32'(sr));
    check({tag, "_inflight"}, 32'(inflight), 32'(inf));
    check({tag, "_busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    RST = 1'b0; en = 1'b0; clr = 1'b0; data_in = 4'd0; strb_in = 1'b0; tap_sel = 4'd0;
    tick;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_tap_data", 32'(tap_data), 32'd0);
    check("rst_tap_err", 32'(tap_err), 32'd0);
    check_strb("rst", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    #2 RST = 1'b1;

    // Data latency through tap 0 and the output stage.
    en = 1'b1; data_in = 4'd5;
    tick;
    check("lat1_tap_data", 32'(tap_data), 32'd5);
    check("lat1_data_out", 32'(data_out), 32'd0);
    data_in = 4'd8;
    tick;
    check("lat2_tap_data", 32'(tap_data), 32'd8);
    check("lat2_data_out", 32'(data_out), 32'd5);
    data_in = 4'd0;
    tick;
    check("lat3_data_out", 32'(data_out), 32'd8);
    check("lat3_tap_data", 32'(tap_data), 32'd0);
    tap_sel = 4'd1;
    #1;
    check("tap1_data", 32'(tap_data), 32'd8);
    check("tap1_err", 32'(tap_err), 32'd0);
    tap_sel = 4'd0;

    // Two-edge strobe chain.
    strb_in = 1'b1;
    tick; check_strb("chain1", 1'b1, 1'b0, 1'b0, 1, 1'b1);
    tick; check_strb("chain2", 1'b1, 1'b1, 1'b1, 2, 1'b1);
    strb_in = 1'b0;
    tick; check_strb("chain3", 1'b0, 1'b1, 1'b0, 1, 1'b1);
    tick; check_strb("chain4", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Stall with one strobe in stage 1; inputs change but must not be captured.
    strb_in = 1'b1; data_in = 4'd3;
    tick; check_strb("stall0", 1'b1, 1'b0, 1'b0, 1, 1'b1);
    en = 1'b0; strb_in = 1'b0; data_in = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_strb("stall_hold", 1'b1, 1'b0, 1'b0, 1, 1'b1);
      check("stall_tap_data", 32'(tap_data), 32'd3);
    end
    en = 1'b1;
    tick;
    check_strb("resume1", 1'b0, 1'b1, 1'b1, 1, 1'b1);
    check("resume1_data_out", 32'(data_out), 32'd3);
    check("resume1_tap_data", 32'(tap_data), 32'd9);
    tick; check_strb("resume2", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Flush a full pipeline while a new strobe is offered.
    strb_in = 1'b1;
    tick; tick;
    check_strb("preflush", 1'b1, 1'b1, 1'b1, 2, 1'b1);
    clr = 1'b1;
    tick; check_strb("flush", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    clr = 1'b0; strb_in = 1'b0;
    tick; check_strb("postflush", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Asynchronous reset between edges while busy.
    strb_in = 1'b1; data_in = 4'd7;
    tick; tick;
    check_strb("prereset", 1'b1, 1'b1, 1'b1, 2, 1'b1);
    #2 RST = 1'b0; tap_sel = 4'd3;
    #1;
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_tap_data", 32'(tap_data), 32'd0);
    check("arst_tap_err", 32'(tap_err), 32'd1);
    check_strb("arst", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    #2 RST = 1'b1;

    // First edges after release; tap_sel=3 must mirror stage 2.
    data_in = 4'd6; strb_in = 1'b1;
    tick;
    check_strb("rel1", 1'b0, 1'b0, 1'b0, 1, 1'b1);
    tick;
    check_strb("rel2", 1'b1, 1'b1, 1'b1, 2, 1'b1);
    check("rel2_tap_data", 32'(tap_data), 32'd6);
    check("rel2_data_out", 32'(data_out), 32'd6);
    check("rel2_tap_err", 32'(tap_err), 32'd1);
    tick;
    check_strb("steady_high", 1'b1, 1'b1, 1'b0, 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
